ga_selection_engine: RTL and testbench
======================================

Name: ga_selection_engine

Overview:
- Hardware consumer of a GA population's fitness values: performs one parent selection per request and returns the chosen chromosome index.
- Supports PROPORTIONATE (roulette wheel) and RANK selection, matching the selection_t encoding used by the software GA components.
- Sits between the population fitness writer (software/driver side) and the hardware chromosome fetch logic.

Parameters:
- POP_SIZE, 16, number of chromosomes; must be a power of 2 and at least 2.
- FIT_WIDTH, 16, width of one unsigned fitness value.
- IDX_WIDTH, $clog2(POP_SIZE), width of a chromosome index (derived).
- SUM_W, FIT_WIDTH+IDX_WIDTH, width of accumulated fitness, threshold and random input (derived).

Ports:
- CLK  in  1  clock.
- RESET  in  1  reset.
- wr_en  in  1  fitness write strobe.
- wr_idx  in  IDX_WIDTH  chromosome index to write.
- wr_fitness  in  FIT_WIDTH  fitness value.
- start  in  1  selection request.
- mode  in  1  selection_t: 0 = PROPORTIONATE, 1 = RANK.
- rand_val  in  SUM_W  uniform random fraction, interpreted as rand_val / 2^SUM_W.
- busy  out  1  engine not idle.
- sel_valid  out  1  result valid.
- sel_ready  in  1  result accepted.
- sel_idx  out  IDX_WIDTH  selected chromosome index.
- zero_total  out  1  PROPORTIONATE total was 0; fallback index used.

Interface decision: one clock, CLK; RESET is asynchronous and active-high.

Behaviour:
- Reset values:
  - busy, sel_valid, sel_idx and zero_total are 0; FSM is in IDLE.
  - The fitness register array, accumulator and threshold are 0.
- Fitness writes:
  - Accepted only in IDLE; fit[wr_idx] <= wr_fitness.
  - Writes while busy=1 are ignored.
- RANK precondition: software writes the population sorted ascending by fitness, so index i carries weight i+1.
- start:
  - Sampled only in IDLE; mode and rand_val are latched in that cycle.
  - start is ignored while busy.
  - A write and a start in the same IDLE cycle: the write takes effect first, and the selection uses the updated value.
- FSM IDLE -> SUM (PROPORTIONATE) or THRESH (RANK):
  - SUM: accumulates fit[0..POP_SIZE-1], one element per cycle, for POP_SIZE cycles, then goes to THRESH.
  - RANK total is the constant POP_SIZE*(POP_SIZE+1)/2.
- THRESH (1 cycle):
  - thr <= (rand_val_latched * total) >> SUM_W, using a full 2*SUM_W-bit product.
  - If PROPORTIONATE and total == 0: sel_idx <= rand_val_latched[IDX_WIDTH-1:0], zero_total <= 1, go to DONE.
  - Otherwise clear acc and go to SCAN with j = 0.
- SCAN:
  - Each cycle, acc_next = acc + w(j), where w(j) = fit[j] (PROPORTIONATE) or j+1 (RANK).
  - If thr < acc_next: sel_idx <= j, go to DONE. Otherwise j <= j+1.
  - thr < total always holds, so a hit occurs no later than j = POP_SIZE-1.
  - As a safety net, j = POP_SIZE-1 forces a hit.
- DONE: sel_valid = 1, and sel_idx and zero_total are held stable until sel_valid && sel_ready; then go to IDLE.
  - sel_ready may already be high on the first DONE cycle; this gives a 1-cycle result.
- Zero-weight entries are never selected in PROPORTIONATE unless total == 0.
- busy = 1 in every state except IDLE.
- zero_total is cleared on the next accepted start.
- Latency, with start accepted at cycle 0 and hit at index j:
  - PROPORTIONATE: sel_valid first high at cycle POP_SIZE+3+j.
  - RANK: sel_valid first high at cycle 3+j.
  - Zero total: sel_valid first high at cycle POP_SIZE+2.
- Mid-operation reset: asynchronously returns to IDLE with all state cleared.
- Arithmetic:
  - acc and total are SUM_W bits wide and cannot overflow (POP_SIZE * (2^FIT_WIDTH - 1) < 2^SUM_W).
  - All values are unsigned.

Decomposition:
- Shared package ga_hw_pkg holds:
  - the selection_t enum (PROPORTIONATE=0, RANK=1);
  - the state enum {IDLE, SUM, THRESH, SCAN, DONE};
  - the function computing the rank total.
- One sub-module: ga_fitness_regfile (write port plus a single indexed read port, async clear), read by both SUM and SCAN.
- FSM, accumulator and threshold multiply live in the top level.

Test Plan:
- POP_SIZE=4, FIT_WIDTH=8 (SUM_W=10), fitness {10,20,30,40}, PROPORTIONATE, rand_val=512 -> thr=50, sel_idx=2, sel_valid first high at cycle 9, zero_total=0.
- Same fitness, rand_val=0 -> sel_idx=0; rand_val=1023 -> thr=99, sel_idx=3.
- RANK, rand_val=512 -> total=10, thr=5, sel_idx=2, sel_valid first high at cycle 5; rand_val=0 -> sel_idx=0.
- Fitness all 0, PROPORTIONATE, rand_val=0x3FF -> sel_idx=3, zero_total=1, sel_valid at cycle 6.
- Hold sel_ready=0 for 5 cycles in DONE:
  - sel_idx stays stable and a second start is ignored;
  - a write issued during DONE leaves fit unchanged;
  - a start issued in the cycle after the handshake is accepted.
- Assert RESET during SCAN -> busy, sel_valid and sel_idx are 0 immediately; a rewrite and restart then produces correct results.

Source files
------------

// File: rtl/ga_hw_pkg.sv
// Shared GA hardware types: selection method encoding, engine states, rank total helper.
package ga_hw_pkg;

    typedef enum logic {
        PROPORTIONATE = 1'b0,
        RANK          = 1'b1
    } selection_t;

    typedef enum logic [2:0] {
        IDLE,
        SUM,
        THRESH,
        SCAN,
        DONE
    } state_t;

    // Sum of rank weights 1..pop for an ascending-sorted population
    function automatic int unsigned rank_total(input int unsigned pop);
        return (pop * (pop + 1)) / 2;
    endfunction

endpackage

// File: rtl/ga_fitness_regfile.sv
// Fitness storage: one write port, one combinational indexed read port, async clear.
module ga_fitness_regfile #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 16,
    parameter int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/ga_selection_engine.sv
// GA parent selection engine: roulette-wheel or rank selection over a stored fitness array,
// one selection per request, result held until accepted.
module ga_selection_engine
    import ga_hw_pkg::*;
#(
    parameter int unsigned POP_SIZE  = 16,
    parameter int unsigned FIT_WIDTH = 16,
    parameter int unsigned IDX_WIDTH = $clog2(POP_SIZE),
    parameter int unsigned SUM_W     = FIT_WIDTH + IDX_WIDTH
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 wr_en,
    input  logic [IDX_WIDTH-1:0] wr_idx,
    input  logic [FIT_WIDTH-1:0] wr_fitness,
    input  logic                 start,
    input  logic                 mode,
    input  logic [SUM_W-1:0]     rand_val,
    output logic                 busy,
    output logic                 sel_valid,
    input  logic                 sel_ready,
    output logic [IDX_WIDTH-1:0] sel_idx,
    output logic                 zero_total
);

    localparam int unsigned          PROD_W   = 2 * SUM_W;
    localparam logic [SUM_W-1:0]     RANK_SUM = SUM_W'(rank_total(POP_SIZE));
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(POP_SIZE - 1);

    state_t                 state;
    state_t                 next_state;
    selection_t             mode_q;
    logic [SUM_W-1:0]       rand_q;
    logic [SUM_W-1:0]       acc;
    logic [SUM_W-1:0]       thr;
    logic [IDX_WIDTH-1:0]   j;
    logic [FIT_WIDTH-1:0]   fit_rd;
    logic                   busy_d;
    logic                   valid_d;

    logic [SUM_W-1:0]       total_c;
    logic [PROD_W-1:0]      prod_c;
    logic [SUM_W-1:0]       thr_c;
    logic [SUM_W-1:0]       w_c;
    logic [SUM_W-1:0]       acc_next_c;
    logic                   hit_c;
    logic                   zero_c;

    ga_fitness_regfile #(
        .DEPTH (POP_SIZE),
        .WIDTH (FIT_WIDTH),
        .IDX_W (IDX_WIDTH)
    ) u_fit (
        .clk     (CLK),
        .rst     (RESET),
        .wr_en   (wr_en && (state == IDLE)),
        .wr_idx  (wr_idx),
        .wr_data (wr_fitness),
        .rd_idx  (j),
        .rd_data (fit_rd)
    );

    // Selection arithmetic; in THRESH acc still holds the PROPORTIONATE total
    always_comb begin
        total_c    = (mode_q == RANK) ? RANK_SUM : acc;
        prod_c     = PROD_W'(rand_q) * PROD_W'(total_c);
        thr_c      = SUM_W'(prod_c >> SUM_W);
        w_c        = (mode_q == RANK) ? (SUM_W'(j) + SUM_W'(1)) : SUM_W'(fit_rd);
        acc_next_c = acc + w_c;
        hit_c      = (thr < acc_next_c) || (j == LAST_IDX);
        zero_c     = (mode_q == PROPORTIONATE) && (acc == '0);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = (selection_t'(mode) == RANK) ? THRESH : SUM;
            SUM:     if (j == LAST_IDX) next_state = THRESH;
            THRESH:  next_state = zero_c ? DONE : SCAN;
            SCAN:    if (hit_c) next_state = DONE;
            DONE:    if (sel_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Status flags follow the state being entered so they are registered yet aligned
    always_comb begin
        busy_d  = 1'b0;
        valid_d = 1'b0;
        busy_d  = (next_state != IDLE);
        valid_d = (next_state == DONE);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            busy      <= 1'b0;
            sel_valid <= 1'b0;
        end else begin
            busy      <= busy_d;
            sel_valid <= valid_d;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            mode_q     <= PROPORTIONATE;
            rand_q     <= '0;
            acc        <= '0;
            thr        <= '0;
            j          <= '0;
            sel_idx    <= '0;
            zero_total <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mode_q     <= selection_t'(mode);
                        rand_q     <= rand_val;
                        acc        <= '0;
                        j          <= '0;
                        zero_total <= 1'b0;
                    end
                end
                SUM: begin
                    acc <= acc + SUM_W'(fit_rd);
                    j   <= j + IDX_WIDTH'(1);
                end
                THRESH: begin
                    thr <= thr_c;
                    j   <= '0;
                    if (zero_c) begin
                        sel_idx    <= rand_q[IDX_WIDTH-1:0];
                        zero_total <= 1'b1;
                    end else begin
                        acc <= '0;
                    end
                end
                SCAN: begin
                    if (hit_c) begin
                        sel_idx <= j;
                    end else begin
                        acc <= acc_next_c;
                        j   <= j + IDX_WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ga_selection_engine.sv
// Self-checking bench for ga_selection_engine with a transaction-level reference model.
module tb_ga_selection_engine;

    localparam int unsigned P  = 4;
    localparam int unsigned FW = 8;
    localparam int unsigned IW = 2;
    localparam int unsigned SW = FW + IW;

    logic          CLK = 1'b0;
    logic          RESET = 1'b1;
    logic          wr_en = 1'b0;
    logic [IW-1:0] wr_idx = '0;
    logic [FW-1:0] wr_fitness = '0;
    logic          start = 1'b0;
    logic          mode = 1'b0;
    logic [SW-1:0] rand_val = '0;
    logic          busy;
    logic          sel_valid;
    logic          sel_ready = 1'b0;
    logic [IW-1:0] sel_idx;
    logic          zero_total;

    int pass_cnt = 0;
    int total_cnt = 0;

    ga_selection_engine #(.POP_SIZE(P), .FIT_WIDTH(FW)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .wr_en      (wr_en),
        .wr_idx     (wr_idx),
        .wr_fitness (wr_fitness),
        .start      (start),
        .mode       (mode),
        .rand_val   (rand_val),
        .busy       (busy),
        .sel_valid  (sel_valid),
        .sel_ready  (sel_ready),
        .sel_idx    (sel_idx),
        .zero_total (zero_total)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input longint act, input longint exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    // Reference model state
    int unsigned m_fit [P];
    bit m_busy = 0, m_valid = 0, m_zero = 0;
    int m_idx = 0, m_cnt = 0;
    int p_idx = 0, p_lat = 0;
    bit p_zero = 0;

    // Selection result and latency straight from the selection rules
    function automatic void model_sel(input bit md, input int unsigned r,
                                      output int idx, output bit z, output int lat);
        longint unsigned total = 0, thr, cum = 0;
        idx = P - 1;
        z = 0;
        if (md) total = P * (P + 1) / 2;
        else foreach (m_fit[k]) total += m_fit[k];
        if (!md && total == 0) begin
            idx = int'(r % P);
            z = 1;
            lat = P + 2;
            return;
        end
        thr = (longint'(r) * total) >> SW;
        for (int k = 0; k < int'(P); k++) begin
            cum += md ? longint'(k + 1) : longint'(m_fit[k]);
            if (thr < cum) begin
                idx = k;
                break;
            end
        end
        lat = (md ? 3 : P + 3) + idx;
    endfunction

    always @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            m_busy = 0; m_valid = 0; m_zero = 0; m_idx = 0; m_cnt = 0;
            foreach (m_fit[k]) m_fit[k] = 0;
        end else if (!m_busy) begin
            if (wr_en) m_fit[wr_idx] = wr_fitness;
            if (start) begin
                model_sel(mode, rand_val, p_idx, p_zero, p_lat);
                m_busy = 1;
                m_zero = 0;
                m_cnt = p_lat - 1;
            end
        end else if (!m_valid) begin
            m_cnt--;
            if (m_cnt == 0) begin
                m_valid = 1;
                m_idx = p_idx;
                m_zero = p_zero;
            end
        end else if (sel_ready) begin
            m_valid = 0;
            m_busy = 0;
        end
    end

    // Every-cycle comparison against the model
    always @(negedge CLK) begin
        chk("busy", busy, m_busy);
        chk("sel_valid", sel_valid, m_valid);
        chk("sel_idx", sel_idx, m_idx);
        chk("zero_total", zero_total, m_zero);
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic wr(input int idx, input int val);
        wr_en = 1; wr_idx = IW'(idx); wr_fitness = FW'(val);
        step();
        wr_en = 0;
    endtask

    task automatic load4(input int a, input int b, input int c, input int d);
        wr(0, a); wr(1, b); wr(2, c); wr(3, d);
    endtask

    // Called one cycle after start; returns the cycle sel_valid was first seen
    task automatic wait_valid(input string nm, output int lat);
        lat = 1;
        forever begin
            @(negedge CLK);
            if (sel_valid) break;
            if (lat >= 40) begin
                chk({nm, " timeout"}, 0, 1);
                break;
            end
            step();
            lat++;
        end
    endtask

    task automatic run_sel(input bit md, input int r, input int e_idx, input bit e_z,
                           input int e_lat, input string nm);
        int lat;
        mode = md; rand_val = SW'(r); start = 1;
        step();
        start = 0;
        wait_valid(nm, lat);
        chk({nm, " latency"}, lat, e_lat);
        chk({nm, " idx"}, sel_idx, e_idx);
        chk({nm, " zero"}, zero_total, e_z);
        sel_ready = 1;
        step();
        sel_ready = 0;
    endtask

    initial begin
        int lat;
        repeat (2) @(posedge CLK);
        #1;
        chk("reset busy", busy, 0);
        chk("reset valid", sel_valid, 0);
        chk("reset idx", sel_idx, 0);
        RESET = 0;
        step();

        load4(10, 20, 30, 40);
        run_sel(0, 512, 2, 0, 9, "prop512");
        run_sel(0, 0, 0, 0, 7, "prop0");
        run_sel(0, 1023, 3, 0, 10, "prop1023");
        run_sel(1, 512, 2, 0, 5, "rank512");
        run_sel(1, 0, 0, 0, 3, "rank0");

        load4(0, 0, 0, 0);
        run_sel(0, 1023, 3, 1, 6, "zero_total");

        // Result held in DONE while writes and a second start are ignored
        load4(10, 20, 30, 40);
        mode = 0; rand_val = 512; start = 1;
        step();
        start = 0;
        wait_valid("hold", lat);
        chk("hold latency", lat, 9);
        step();
        for (int k = 0; k < 5; k++) begin
            start = 1; mode = 1; rand_val = 0;
            wr_en = 1; wr_idx = 2; wr_fitness = 0;
            step();
            chk("hold idx", sel_idx, 2);
            chk("hold valid", sel_valid, 1);
        end
        start = 0; wr_en = 0;
        sel_ready = 1;
        step();
        sel_ready = 0;
        run_sel(0, 512, 2, 0, 9, "after_hold");

        // Ready already high on the first DONE cycle
        sel_ready = 1;
        mode = 1; rand_val = 1023; start = 1;
        step();
        start = 0;
        wait_valid("early_ready", lat);
        chk("early_ready latency", lat, 6);
        step();
        chk("early_ready drop", sel_valid, 0);
        sel_ready = 0;

        // Reset in the middle of SCAN
        mode = 0; rand_val = 1023; start = 1;
        step();
        start = 0;
        repeat (6) step();
        chk("pre_reset busy", busy, 1);
        #2 RESET = 1;
        #1;
        chk("midreset busy", busy, 0);
        chk("midreset valid", sel_valid, 0);
        chk("midreset idx", sel_idx, 0);
        step();
        RESET = 0;
        step();
        load4(10, 20, 30, 40);
        run_sel(0, 512, 2, 0, 9, "post_reset");

        // Randomized transactions checked by the model
        for (int t = 0; t < 60; t++) begin
            int nw = int'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) load4(0, 0, 0, 0);
            for (int k = 0; k < nw; k++)
                wr(int'($urandom_range(0, P - 1)),
                   ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 255)));
            if ($urandom_range(0, 1) == 1) begin
                wr_en = 1; wr_idx = IW'($urandom_range(0, P - 1));
                wr_fitness = FW'($urandom_range(0, 255));
            end
            mode = 1'($urandom_range(0, 1));
            rand_val = SW'($urandom);
            sel_ready = 1'($urandom_range(0, 3) == 0);
            start = 1;
            step();
            start = 0; wr_en = 0;
            wait_valid("random", lat);
            if (!sel_ready) begin
                repeat ($urandom_range(0, 3)) step();
                sel_ready = 1;
            end
            step();
            sel_ready = 0;
        end

        repeat (2) step();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
